// File: rtl/fp_add_pkg.sv
// Shared encodings and constants for the fp adder sequencer slice.
// Pure declarations: no logic, no latency, no flow control.
package fp_add_pkg;
    localparam int DEF_WIDTH = 32;
    localparam logic [31:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RELEASE = 3'd2,
        S_BUSY    = 3'd3,
        S_HOLD    = 3'd4
    } seq_state_t;
endpackage

// File: rtl/fp_add_sequencer_if.sv
// Host operand/result streams plus the adder start/done handshake.
// master = sequencer side, slave = host stream logic and adder controller.
interface fp_add_sequencer_if import fp_add_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_R;
    logic             out_err;
    logic [CNT_W-1:0] op_count;
    logic             busy;
    logic             adder_start;
    logic             adder_done;
    logic [WIDTH-1:0] adder_A;
    logic [WIDTH-1:0] adder_B;
    logic [WIDTH-1:0] adder_R;

    modport master (
        input  in_valid, in_A, in_B, out_ready, adder_done, adder_R,
        output in_ready, out_valid, out_R, out_err, op_count, busy,
               adder_start, adder_A, adder_B
    );

    modport slave (
        output in_valid, in_A, in_B, out_ready, adder_done, adder_R,
        input  in_ready, out_valid, out_R, out_err, op_count, busy,
               adder_start, adder_A, adder_B
    );
endinterface

// File: rtl/fp_operand_fifo.sv
// Operand-pair FIFO, registered storage with no fall-through.
// Latency: a push is visible at head one cycle later.
// Backpressure: full is raised at DEPTH entries; pushes while full are ignored.
module fp_operand_fifo import fp_add_pkg::*; #(
    parameter int W     = 2 * DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra MSB on each pointer separates full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop && !empty)
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fp_add_sequencer.sv
// Queues operand pairs and runs one start/done transaction at a time on the fp adder.
// Latency: push to out_valid = 4 + adder busy cycles. Optional watchdog: FP_ADD_SEQ_TIMEOUT_EN.
// Backpressure: in_ready = !full; result held in S_HOLD until out_ready, no new add meanwhile.
module fp_add_sequencer import fp_add_pkg::*; #(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                CLK,
    input  logic                rst,
    fp_add_sequencer_if.master  bus
);
    seq_state_t         state;
    seq_state_t         state_nxt;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;
    logic               timeout_hit;
    logic               cap_ok;
    logic               cap_tmo;

    assign bus.in_ready    = rst && !full;
    assign push            = bus.in_valid && bus.in_ready;
    assign pop             = (state == S_IDLE) && !empty && bus.adder_done;
    assign bus.adder_start = (state == S_START);
    assign bus.out_valid   = (state == S_HOLD);
    assign bus.busy        = (state != S_IDLE) || !empty;

    fp_operand_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.in_A, bus.in_B}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

`ifdef FP_ADD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge CLK) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (pop)
            tmo_cnt <= '0;
        else if (state == S_RELEASE || state == S_BUSY)
            tmo_cnt <= tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
    end

    assign timeout_hit = (state == S_RELEASE || state == S_BUSY) &&
                         (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign cap_ok  = (state == S_BUSY) && bus.adder_done;
    // The watchdog only wins when the normal exit of this cycle is absent.
    assign cap_tmo = timeout_hit && !cap_ok && !((state == S_RELEASE) && !bus.adder_done);

    always_ff @(posedge CLK) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pop) state_nxt = S_START;
            S_START:   state_nxt = S_RELEASE;
            S_RELEASE: begin
                if (!bus.adder_done) state_nxt = S_BUSY;
                else if (cap_tmo)    state_nxt = S_HOLD;
            end
            S_BUSY:    if (cap_ok || cap_tmo) state_nxt = S_HOLD;
            S_HOLD:    if (bus.out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            bus.adder_A  <= '0;
            bus.adder_B  <= '0;
            bus.out_R    <= '0;
            bus.out_err  <= 1'b0;
            bus.op_count <= '0;
        end else begin
            if (pop)
                {bus.adder_A, bus.adder_B} <= head;
            if (cap_ok) begin
                bus.out_R   <= bus.adder_R;
                bus.out_err <= 1'b0;
            end else if (cap_tmo) begin
                bus.out_R   <= WIDTH'(FP_QNAN);
                bus.out_err <= 1'b1;
            end
            if (state == S_HOLD && bus.out_ready)
                bus.op_count <= bus.op_count + CNT_W'(1);
        end
    end
endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Initiator for the floating-point adder's start/done handshake.
- Buffers incoming operand pairs in a small FIFO and issues one add at a time to the adder controller.
- Holds the operands stable for the whole transaction, waits for completion, captures the sum and presents it on a valid/ready result port.
- Sits between the host-side stream logic and the fp adder datapath/controller pair.

Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single).
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with the optional feature.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_A  in  WIDTH  operand A.
- in_B  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_R  out  WIDTH  sum.
- out_err  out  1  result produced by watchdog; 0 without the optional feature.
- op_count  out  CNT_W  completed (handed-off) results, wraps.
- busy  out  1  state other than S_IDLE, or FIFO not empty.
- adder_start  out  1  start to adder controller.
- adder_done  in  1  done from adder controller; high while the adder is idle.
- adder_A  out  WIDTH  operand A to adder, registered.
- adder_B  out  WIDTH  operand B to adder, registered.
- adder_R  in  WIDTH  adder result (sign/exp/mantissa packed).

Behaviour:
- Reset: while rst=0 at a rising edge:
  - state becomes S_IDLE and the FIFO empties.
  - adder_start, out_valid, out_err, adder_A, adder_B, out_R and op_count become 0.
  - in_ready is 0 while rst is low. Otherwise in_ready = !full.
- FIFO:
  - Push on in_valid&in_ready.
  - Pop only in S_IDLE.
  - No fall-through: a pair pushed in cycle n is poppable in cycle n+1 at the earliest.
  - Push and pop in the same cycle are both honoured.
  - Writes into a full FIFO are impossible because in_ready=0.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- State machine:
  - S_IDLE: if FIFO not empty and adder_done=1, pop the head into adder_A/adder_B and go to S_START. If adder_done=0 (adder still busy, e.g. after reset skew), wait.
  - S_START: adder_start=1 for exactly one cycle, then go to S_RELEASE.
  - S_RELEASE: adder_start=0. When adder_done=0 (the adder has accepted; expected the first cycle), go to S_BUSY.
  - S_BUSY: wait for adder_done=1. Then latch out_R<=adder_R, set out_valid=1, out_err=0, and go to S_HOLD.
  - S_HOLD: out_valid stays high and out_R is stable until out_ready=1. On that edge: clear out_valid, op_count+1 (wraps at 2^CNT_W), go to S_IDLE.
- Operand stability: adder_A/adder_B change only on a pop, so they are stable from S_START through result capture. The adder loads them the cycle after start falls.
- Latency: with adder_done=1 and out_ready=1, the first out_valid comes at (push cycle)+4+(adder busy cycles).
- Throughput: one add in flight; the next pop happens only after the result hand-off.
- Reset mid-operation: the transaction is abandoned, the FIFO is flushed, and no result is emitted. The adder is reset by the system reset. If it is not, S_IDLE still blocks until adder_done=1.
- adder_start is never asserted while adder_done=0.

Optional Feature:
- Macro: FP_ADD_SEQ_TIMEOUT_EN.
- With the macro:
  - A counter runs in S_RELEASE and S_BUSY and clears on entry to S_START.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, go to S_HOLD with out_R=32'h7FC00000 (quiet NaN) and out_err=1.
  - op_count still increments on hand-off.
- Without the macro: no counter; the block waits indefinitely; out_err is tied 0.

Decomposition:
- Shared package fp_add_pkg holds:
  - state encoding constants S_IDLE..S_HOLD.
  - FP_QNAN=32'h7FC00000.
  - default WIDTH.
- One natural sub-module: fp_operand_fifo. It is parameterised by 2*WIDTH and DEPTH and exposes push, pop, full, empty and head.

Test Plan:
- 1.0+2.0: push A=32'h3F800000, B=32'h40000000 with an adder model. Required: adder_start high exactly 1 cycle, adder_A/B stable until done rises, out_R=32'h40400000, op_count=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: out_R held, no second adder_start, next pop only after out_ready=1.
- FIFO full: model holds adder_done=0, push 5 pairs. Required: in_ready drops after 4 accepted. Release the model; all 4 results emerge in order, e.g. 1+1=32'h40000000 through 4+4=32'h41000000.
- Handshake guard: adder_done=0 at idle with a pair queued. Required: adder_start stays 0 until done=1, then pulses once.
- Reset mid-op: rst=0 during S_BUSY. Required: out_valid=0, FIFO empty, in_ready=0 during reset then 1, op_count=0, no stray result.
- With FP_ADD_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: model never raises done. Required: out_R=32'h7FC00000, out_err=1, op_count increments on hand-off.
